// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared definitions for the bit-serial arithmetic blocks (subtractor now,
//   adder/comparator later): the control FSM state encoding.
package serial_pkg;

  // Control FSM states for the serial datapath blocks.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_pkg

// File: rtl/full_adder.sv
// full_adder
//   One-bit full adder cell used as the bit slice of the serial datapaths.
// Ports
//   A, B  : addend bits
//   Cin   : carry in
//   S     : sum bit
//   Cout  : carry out
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule : full_adder

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: diff = a - b (mod 2^WIDTH), computed LSB-first,
//   one bit per clock, as a + ~b + 1 through a single full_adder cell.
//   Start/done handshake; busy is high for exactly WIDTH cycles and done
//   pulses for one cycle, from which diff/borrow are valid and held.
// Parameters
//   WIDTH : operand/result width, 1..32
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request, honoured only when idle or in the done cycle
//   a, b   : minuend / subtrahend, captured when start is accepted
//   busy   : bits are being processed
//   done   : one-cycle completion pulse
//   diff   : a - b mod 2^WIDTH
//   borrow : 1 when a < b (unsigned)
//   zero   : diff == 0              (only with SERIAL_SUB_FLAGS_EN)
//   ovf    : signed overflow        (only with SERIAL_SUB_FLAGS_EN)
// Build option
//   SERIAL_SUB_FLAGS_EN : adds the zero/ovf flag outputs.
module serial_subtractor
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic             sum;
  logic             cout;
  logic             last_bit;

  full_adder u_bit (
    .A    (a_sh_reg[0]),
    .B    (b_sh_reg[0]),
    .Cin  (carry_reg),
    .S    (sum),
    .Cout (cout)
  );

  // Result fills from the top: each new sum bit enters at the MSB and the
  // earlier bits move down, so after WIDTH steps bit 0 holds the first sum.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
      assign result_next[gi] = result_reg[gi+1];
    end
  endgenerate
  assign result_next[WIDTH-1] = sum;

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb_reg;
  logic b_msb_reg;
  logic zero_reg;
  logic ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            // Two's complement subtract: invert b here, +1 via carry seed.
            a_sh_reg   <= a;
            b_sh_reg   <= ~b;
            carry_reg  <= 1'b1;
            cnt_reg    <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_BUSY;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_reg  <= a[WIDTH-1];
            b_msb_reg  <= b[WIDTH-1];
`endif
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          result_reg <= result_next;
          carry_reg  <= cout;
          cnt_reg    <= cnt_reg + CW'(1);
          if (last_bit) begin
            // Take the final bit straight from the cell so the result is
            // complete in the same edge that enters DONE.
            state_reg  <= ST_DONE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            diff_reg   <= result_next;
            borrow_reg <= ~cout;
`ifdef SERIAL_SUB_FLAGS_EN
            zero_reg   <= (result_next == '0);
            // The final sum bit is the result MSB.
            ovf_reg    <= (a_msb_reg != b_msb_reg) && (sum != a_msb_reg);
`endif
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign diff   = diff_reg;
  assign borrow = borrow_reg;
`ifdef SERIAL_SUB_FLAGS_EN
  assign zero   = zero_reg;
  assign ovf    = ovf_reg;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed and random operations on an 8-bit serial_subtractor, checked
//   against plain-arithmetic expectations computed in the bench.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero   (zero),
    .ovf    (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference results from plain integer arithmetic.
  task automatic check_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb);
    int unsigned ua;
    int unsigned ub;
    int          sd;
    ua = ta;
    ub = tb;
    chk({tag, "_diff"}, 32'(diff), 32'((ua - ub) % 256));
    chk({tag, "_borrow"}, 32'(borrow), 32'(ua < ub));
`ifdef SERIAL_SUB_FLAGS_EN
    sd = int'($signed(ta)) - int'($signed(tb));
    chk({tag, "_zero"}, 32'(zero), 32'(ta == tb));
    chk({tag, "_ovf"}, 32'(ovf), 32'((sd > 127) || (sd < -128)));
`else
    sd = 0;
`endif
    $display("op %s: a=%02h b=%02h diff=%02h borrow=%0d sd=%0d", tag, ta, tb, diff, borrow, sd);
  endtask

  // Issue one op with a single-cycle start; count busy cycles until done.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;   // late operand changes must not matter
    cycles = 0; busy_cnt = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(cycles), 32'(W));
    chk({tag, "_busycnt"}, 32'(busy_cnt), 32'(W));
    check_result(tag, ta, tb);
    @(negedge clk);
    chk({tag, "_donefall"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n_done;
    int d1;
    int d2;
    int cyc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;

    do_op("5m3", 8'd5, 8'd3);
    do_op("3m5", 8'd3, 8'd5);
    do_op("0m0", 8'd0, 8'd0);
    do_op("80m01", 8'h80, 8'h01);
    do_op("7Fm FF", 8'h7F, 8'hFF);
    do_op("FFmFF", 8'hFF, 8'hFF);
    do_op("00mFF", 8'h00, 8'hFF);

    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op($sformatf("rnd%0d", i), ra, rb);
    end

    // start re-pulsed during BUSY with other operands is ignored.
    @(negedge clk);
    a = 8'd100; b = 8'd42; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'd1; b = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        n_done++;
        if (n_done == 1) check_result("ignore", 8'd100, 8'd42);
      end
      @(negedge clk);
    end
    chk("ignore_ndone", 32'(n_done), 32'd1);

    // start held high: back-to-back ops, done 9 cycles apart.
    @(negedge clk);
    a = 8'd20; b = 8'd7; start = 1'b1;
    @(negedge clk);
    a = 8'd7; b = 8'd20;   // captured by the second op at the DONE cycle
    d1 = -1; d2 = -1; cyc = 0;
    while (d2 < 0 && cyc < 40) begin
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc;
          check_result("b2b1", 8'd20, 8'd7);
        end else begin
          d2 = cyc;
          start = 1'b0;
          check_result("b2b2", 8'd7, 8'd20);
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_gap", 32'(d2 - d1), 32'd9);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of an op aborts it.
    do_op("pre_rst", 8'h33, 8'h11);
    @(negedge clk);
    a = 8'h90; b = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_borrow", 32'(borrow), 32'd0);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    chk("mid_rst_quiet", 32'(n_done), 32'd0);

    do_op("post_rst", 8'h10, 8'h90);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_serial_subtractor
